// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - state encoding, default timing and counter widths for the PLL lock supervisor
package pll_sup_pkg;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_e;

   localparam int DEF_RST_PULSE     = 16;
   localparam int DEF_LOCK_TIMEOUT  = 50000;
   localparam int DEF_STABLE_CYCLES = 1024;
   localparam int DEF_MAX_RETRIES   = 7;

   localparam int RETRY_W = 4;
   localparam int LOSS_W  = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/cdc_sync2.sv
// rtl/cdc_sync2.sv - two-flop single-bit synchronizer, async active-low reset to 0
module cdc_sync2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL areset/lock sequencer gating the system reset
// Optional lock-loss counter built when PLL_SUPERVISOR_LOSS_CNT_EN is defined.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_PULSE     = DEF_RST_PULSE,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_pll_locked,
   input  logic              i_relock,
   output logic              o_pll_areset,
   output logic              o_rst,
   output logic              o_ready,
   output logic              o_fail,
   output logic [RETRY_W-1:0] o_retries,
   output logic [LOSS_W-1:0]  o_loss_cnt
);

   localparam int TMR_W = $clog2(max3(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

   state_e             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [RETRY_W-1:0] retries_q, retries_d, retries_inc;
   logic               areset_q, rst_q, ready_q, fail_q;
   logic               lock_loss;
   logic               lk;

   cdc_sync2 u_lock_sync (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .d_i    (i_pll_locked),
      .q_o    (lk)
   );

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      retries_d   = retries_q;
      lock_loss   = 1'b0;
      retries_inc = (retries_q == {RETRY_W{1'b1}}) ? retries_q : retries_q + RETRY_W'(1);

      if (i_relock) begin
         state_d   = RESET_PLL;
         retries_d = '0;
      end else begin
         case (state_q)
            RESET_PLL: begin
               if (timer_q == TMR_W'(RST_PULSE - 1)) state_d = WAIT_LOCK;
               else                                  timer_d = timer_q + TMR_W'(1);
            end
            WAIT_LOCK: begin
               if (lk) begin
                  state_d = STABLE;
               end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                  retries_d = retries_inc;
                  state_d   = ((MAX_RETRIES != 0) && (retries_inc == RETRY_W'(MAX_RETRIES)))
                              ? FAIL : RESET_PLL;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            STABLE: begin
               // The lk sample that moved us here is not counted, giving STABLE_CYCLES+3 release latency.
               if (!lk) begin
                  state_d = WAIT_LOCK;
               end else if (timer_q == TMR_W'(STABLE_CYCLES)) begin
                  state_d   = RUN;
                  retries_d = '0;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            RUN: begin
               if (!lk) begin
                  state_d   = RESET_PLL;
                  lock_loss = 1'b1;
               end
            end
            FAIL:    state_d = FAIL;
            default: state_d = RESET_PLL;
         endcase
      end

      if ((state_d != state_q) || i_relock) timer_d = '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= RESET_PLL;
         timer_q   <= '0;
         retries_q <= '0;
         areset_q  <= 1'b1;
         rst_q     <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         retries_q <= retries_d;
         areset_q  <= (state_d == RESET_PLL) || (state_d == FAIL);
         rst_q     <= (state_d != RUN);
         ready_q   <= (state_d == RUN);
         fail_q    <= (state_d == FAIL);
      end
   end

`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
   logic [LOSS_W-1:0] loss_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                             loss_q <= '0;
      else if (lock_loss && (loss_q != '1))    loss_q <= loss_q + LOSS_W'(1);
   end

   assign o_loss_cnt = loss_q;
`else
   logic loss_unused;
   assign loss_unused = lock_loss;
   assign o_loss_cnt  = '0;
`endif

   assign o_pll_areset = areset_q;
   assign o_rst        = rst_q;
   assign o_ready      = ready_q;
   assign o_fail       = fail_q;
   assign o_retries    = retries_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

   localparam int RP = 4;
   localparam int LT = 20;
   localparam int SC = 8;
   localparam int MR = 3;
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       locked;
   logic       relock;
   logic       areset, srst, ready, fail;
   logic [3:0] retries;
   logic [7:0] loss_cnt;

   int n_pass  = 0;
   int n_total = 0;

   pll_lock_supervisor #(
      .RST_PULSE     (RP),
      .LOCK_TIMEOUT  (LT),
      .STABLE_CYCLES (SC),
      .MAX_RETRIES   (MR)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_pll_locked (locked),
      .i_relock     (relock),
      .o_pll_areset (areset),
      .o_rst        (srst),
      .o_ready      (ready),
      .o_fail       (fail),
      .o_retries    (retries),
      .o_loss_cnt   (loss_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_loss(input int v);
      return LOSS_EN ? v : 0;
   endfunction

   task automatic count_high(output int n);
      n = 0;
      while (areset === 1'b1 && n < 100) begin
         n++;
         tick();
      end
   endtask

   task automatic count_low(output int n);
      n = 0;
      while (areset === 1'b0 && n < 100) begin
         n++;
         tick();
      end
   endtask

   // Edges from the first edge that samples locked=1 to the edge that drops o_rst.
   task automatic release_latency(output int lat);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (srst !== 1'b0 && n < 100);
      lat = n - 1;
   endtask

   task automatic do_loss(output bit ok);
      int n;
      locked = 1'b0;
      repeat (3) tick();
      locked = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      ok = (ready === 1'b1);
   endtask

   initial begin
      int n;
      bit ok;
      bit all_ok;

      rst_n  = 1'b0;
      locked = 1'b0;
      relock = 1'b0;
      repeat (3) tick();
      check("rst_areset",  areset,   1);
      check("rst_rst",     srst,     1);
      check("rst_ready",   ready,    0);
      check("rst_fail",    fail,     0);
      check("rst_retries", retries,  0);
      check("rst_loss",    loss_cnt, 0);

      // Clean lock
      rst_n = 1'b1;
      count_high(n);
      check("clean_areset_pulse", n, RP);
      repeat (6) tick();
      locked = 1'b1;
      release_latency(n);
      check("clean_release_lat", n, SC + 3);
      check("clean_ready",   ready,   1);
      check("clean_retries", retries, 0);
      check("clean_fail",    fail,    0);
      check("clean_areset",  areset,  0);

      // Loss of lock in RUN
      repeat (5) tick();
      locked = 1'b0;
      tick();
      tick();
      check("loss_ready_d1", ready, 1);
      tick();
      check("loss_rst_d2",    srst,   1);
      check("loss_ready_d2",  ready,  0);
      count_high(n);
      check("loss_areset_pulse", n, RP);
      repeat (3) tick();
      locked = 1'b1;
      release_latency(n);
      check("loss_release_lat", n, SC + 3);
      check("loss_ready",   ready,    1);
      check("loss_cnt_1",   loss_cnt, exp_loss(1));

      // Relock in the same cycle lk falls in RUN
      repeat (4) tick();
      locked = 1'b0;
      tick();
      tick();
      relock = 1'b1;
      tick();
      relock = 1'b0;
      check("relock_run_rst",     srst,     1);
      check("relock_run_areset",  areset,   1);
      check("relock_run_retries", retries,  0);
      check("relock_run_loss",    loss_cnt, exp_loss(1));

      // No lock: MR attempts then FAIL
      for (int k = 1; k <= MR; k++) begin
         count_high(n);
         check($sformatf("nolock_pulse%0d", k), n, RP);
         count_low(n);
         check($sformatf("nolock_gap%0d", k), n, LT);
         check($sformatf("nolock_retries%0d", k), retries, k);
      end
      check("nolock_fail",   fail,   1);
      check("nolock_areset", areset, 1);
      check("nolock_rst",    srst,   1);
      repeat (50) tick();
      check("nolock_fail_held",    fail,    1);
      check("nolock_areset_held",  areset,  1);
      check("nolock_retries_held", retries, MR);

      // Relock from FAIL, then a lock glitch
      relock = 1'b1;
      tick();
      relock = 1'b0;
      check("relock_fail_fail",    fail,    0);
      check("relock_fail_retries", retries, 0);
      count_high(n);
      check("relock_fail_pulse", n, RP);
      repeat (2) tick();
      locked = 1'b1;
      repeat (3) tick();
      locked = 1'b0;
      tick();
      check("glitch_rst_held", srst, 1);
      locked = 1'b1;
      release_latency(n);
      check("glitch_release_lat", n, SC + 3);
      check("glitch_retries",     retries,  0);
      check("glitch_ready",       ready,    1);
      check("glitch_loss",        loss_cnt, exp_loss(1));

      // Repeated losses and saturation
      do_loss(ok);
      check("loss2_relocked", ok, 1);
      check("loss_cnt_2", loss_cnt, exp_loss(2));
      all_ok = 1'b1;
      for (int i = 0; i < 300; i++) begin
         do_loss(ok);
         all_ok = all_ok & ok;
      end
      check("loss300_relocked", all_ok, 1);
      check("loss_cnt_sat", loss_cnt, exp_loss(255));

      // Asynchronous reset mid-run
      repeat (2) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("async_areset",  areset,   1);
      check("async_rst",     srst,     1);
      check("async_ready",   ready,    0);
      check("async_fail",    fail,     0);
      check("async_loss",    loss_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
